count_monitor: RTL and testbench

- Sits directly downstream of the 4-bit free-running counter and samples its `count` output every `clk` edge.
- Classifies each step as hold, increment, wrap, restart or illegal jump.
- Keeps saturating wrap and restart tallies and raises a sticky error on an illegal jump.
- Lab benches use it as a self-checking consumer of the counter stage.

---
 rtl/count_monitor_pkg.sv | 24 ++
 rtl/count_monitor_sat_tally.sv | 25 ++
 rtl/count_monitor.sv | 109 ++++++++++
 tb/tb_count_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// Shared types and helpers for the count_monitor block: FSM states, step
// classes and the maximum-count helper.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    WRAP,
    RESTART,
    JUMP
  } step_e;

  // Largest value a w-bit counter reaches before it wraps to zero.
  function automatic int max_count(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/count_monitor_sat_tally.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// clr is synchronous and wins over inc.
module sat_tally #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] tally
);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tally <= '0;
    end else if (clr) begin
      tally <= '0;
    end else if (inc && (tally != '1)) begin
      tally <= tally + 1'b1;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Watches a free-running counter and classifies each step. Wraps and restarts
// are tallied, and an illegal jump latches a sticky error.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [CNT_W-1:0]   count_in,
  output logic               wrap_pulse,
  output logic               restart_pulse,
  output logic [TALLY_W-1:0] wrap_tally,
  output logic [TALLY_W-1:0] restart_tally,
  output logic               step_err,
  output logic [CNT_W-1:0]   last_count,
  output logic [1:0]         state
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(max_count(CNT_W));

  state_e           st;
  step_e            step;
  logic [CNT_W-1:0] next_count;
  logic             wrap_inc;
  logic             restart_inc;

  assign next_count = last_count + 1'b1;
  assign state      = st;

  // Priority order matters: a hold at MAX must not be read as a wrap, and a
  // return to 0 from MAX is a wrap rather than a restart.
  // NOTE: always_comb assigns a default first so no path leaves step unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    step = JUMP;
    if (count_in == last_count) begin
      step = HOLD;
    end else if ((last_count == MAX) && (count_in == '0)) begin
      step = WRAP;
    end else if (count_in == next_count) begin
      step = INC;
    end else if (count_in == '0) begin
      step = RESTART;
    end
  end

  assign wrap_inc    = (st == TRACK) && (step == WRAP) && !clear;
  assign restart_inc = (st == TRACK) && (step == RESTART) && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= IDLE;
      last_count    <= '0;
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
      step_err      <= 1'b0;
    end else if (clear) begin
      st            <= IDLE;
      last_count    <= '0;
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
      step_err      <= 1'b0;
    end else begin
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
      case (st)
        IDLE: begin
          last_count <= count_in;
          st         <= TRACK;
        end
        TRACK: begin
          last_count    <= count_in;
          wrap_pulse    <= (step == WRAP);
          restart_pulse <= (step == RESTART);
          if (step == JUMP) begin
            step_err <= 1'b1;
            st       <= ERROR;
          end
        end
        ERROR: begin
          st <= ERROR;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  sat_tally #(.W(TALLY_W)) u_wrap_tally (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .clr   (clear),
    .tally (wrap_tally)
  );

  sat_tally #(.W(TALLY_W)) u_restart_tally (
    .clk   (clk),
    .reset (reset),
    .inc   (restart_inc),
    .clr   (clear),
    .tally (restart_tally)
  );

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a table of hand-computed vectors plus
// hand-written sequences for saturation, async reset and clear-vs-wrap.
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] count_in;
  logic       wrap_pulse;
  logic       restart_pulse;
  logic [7:0] wrap_tally;
  logic [7:0] restart_tally;
  logic       step_err;
  logic [3:0] last_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cnt;
    logic       clr;
    logic       wp;
    logic       rp;
    logic [7:0] wt;
    logic [7:0] rt;
    logic       err;
    logic [1:0] st;
    logic [3:0] last;
  } vec_t;

  vec_t vecs[$];

  count_monitor #(.CNT_W(4), .TALLY_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .count_in      (count_in),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .wrap_tally    (wrap_tally),
    .restart_tally (restart_tally),
    .step_err      (step_err),
    .last_count    (last_count),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic clr, input logic wp, input logic rp,
                     input logic [7:0] wt, input logic [7:0] rt, input logic err,
                     input logic [1:0] st, input logic [3:0] last);
    vec_t v;
    v.cnt = c; v.clr = clr; v.wp = wp; v.rp = rp; v.wt = wt;
    v.rt = rt; v.err = err; v.st = st; v.last = last;
    vecs.push_back(v);
  endtask

  // Drive one sample, let one edge take it, then settle 1 time unit past the edge.
  task automatic apply(input logic [3:0] c, input logic clr);
    count_in = c;
    clear    = clr;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, state, 2'd0);
    check({tag, " last_count"}, last_count, 4'd0);
    check({tag, " wrap_tally"}, wrap_tally, 8'd0);
    check({tag, " restart_tally"}, restart_tally, 8'd0);
    check({tag, " pulses"}, {wrap_pulse, restart_pulse}, 2'b00);
    check({tag, " step_err"}, step_err, 1'b0);
  endtask

  initial begin
    int pulse_cnt;
    // Sequence 1: 0..15,0,1 -> one wrap.
    add(4'd0, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd0);
    for (int i = 1; i < 16; i++) add(4'(i), 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'(i));
    add(4'd0, 0, 1, 0, 8'd1, 8'd0, 0, 2'd1, 4'd0);
    add(4'd1, 0, 0, 0, 8'd1, 8'd0, 0, 2'd1, 4'd1);
    // Sequence 2: clear, then 3,4,5,0,1 -> one restart.
    add(4'd0, 1, 0, 0, 8'd0, 8'd0, 0, 2'd0, 4'd0);
    add(4'd3, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd3);
    add(4'd4, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd4);
    add(4'd5, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd5);
    add(4'd0, 0, 0, 1, 8'd0, 8'd1, 0, 2'd1, 4'd0);
    add(4'd1, 0, 0, 0, 8'd0, 8'd1, 0, 2'd1, 4'd1);
    // Sequence 3: clear, then 7,7,7,8 -> holds then an increment.
    add(4'd0, 1, 0, 0, 8'd0, 8'd0, 0, 2'd0, 4'd0);
    add(4'd7, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd7);
    add(4'd7, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd7);
    add(4'd7, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd7);
    add(4'd8, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd8);
    // Sequence 4: clear, 4,5,9 -> jump into ERROR; 10,11,15,0 frozen; clear.
    add(4'd0, 1, 0, 0, 8'd0, 8'd0, 0, 2'd0, 4'd0);
    add(4'd4, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd4);
    add(4'd5, 0, 0, 0, 8'd0, 8'd0, 0, 2'd1, 4'd5);
    add(4'd9, 0, 0, 0, 8'd0, 8'd0, 1, 2'd2, 4'd9);
    add(4'd10, 0, 0, 0, 8'd0, 8'd0, 1, 2'd2, 4'd9);
    add(4'd11, 0, 0, 0, 8'd0, 8'd0, 1, 2'd2, 4'd9);
    add(4'd15, 0, 0, 0, 8'd0, 8'd0, 1, 2'd2, 4'd9);
    add(4'd0, 0, 0, 0, 8'd0, 8'd0, 1, 2'd2, 4'd9);
    add(4'd0, 1, 0, 0, 8'd0, 8'd0, 0, 2'd0, 4'd0);

    reset    = 1'b0;
    clear    = 1'b0;
    count_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].cnt, vecs[i].clr);
      check({tag, " wrap_pulse"}, wrap_pulse, vecs[i].wp);
      check({tag, " restart_pulse"}, restart_pulse, vecs[i].rp);
      check({tag, " wrap_tally"}, wrap_tally, vecs[i].wt);
      check({tag, " restart_tally"}, restart_tally, vecs[i].rt);
      check({tag, " step_err"}, step_err, vecs[i].err);
      check({tag, " state"}, state, vecs[i].st);
      check({tag, " last_count"}, last_count, vecs[i].last);
    end

    // 300 full wraps: tally saturates at 255, pulse keeps firing on every wrap.
    apply(4'd0, 1'b0);
    pulse_cnt = 0;
    for (int w = 1; w <= 300; w++) begin
      for (int k = 1; k < 16; k++) begin
        apply(4'(k), 1'b0);
        if (wrap_pulse) pulse_cnt++;
      end
      apply(4'd0, 1'b0);
      if (wrap_pulse) pulse_cnt++;
      if (w == 1)   check("sat tally after 1 wrap", wrap_tally, 8'd1);
      if (w == 255) check("sat tally after 255 wraps", wrap_tally, 8'd255);
      if (w == 256) check("sat tally after 256 wraps", wrap_tally, 8'd255);
    end
    check("sat wrap pulse count", pulse_cnt, 300);
    check("sat wrap_tally final", wrap_tally, 8'd255);
    check("sat restart_tally", restart_tally, 8'd0);
    check("sat wrap_pulse on last wrap", wrap_pulse, 1'b1);

    // Async reset mid-run, asserted between edges.
    apply(4'd1, 1'b0);
    apply(4'd2, 1'b0);
    apply(4'd7, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    // First sample after reset must not be classified as a restart.
    apply(4'd0, 1'b0);
    check("post-reset restart_pulse", restart_pulse, 1'b0);
    check("post-reset restart_tally", restart_tally, 8'd0);
    check("post-reset state", state, 2'd1);

    // clear coinciding with a 15->0 wrap.
    for (int k = 1; k < 16; k++) apply(4'(k), 1'b0);
    check("pre-clear last_count", last_count, 4'd15);
    apply(4'd0, 1'b1);
    check("clear+wrap wrap_pulse", wrap_pulse, 1'b0);
    check("clear+wrap wrap_tally", wrap_tally, 8'd0);
    check("clear+wrap state", state, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
